fft_bitrev_reorder: RTL and testbench
=====================================

# fft_bitrev_reorder

Output reorder buffer for the pipelined FFT. The SDF butterfly/delay-lane chain emits each N-point frame in bit-reversed index order. This block collects every frame in a ping-pong memory and reads it back in natural index order, one complex sample per enabled cycle, for the downstream consumer. It uses the same `enable` stall convention as the delay lanes.

## Interface
- `N_LOG2`, default 4: log2 of the frame length N (N = 16 by default; legal range 2..10).
- `DATA_W`, default 16: width of each real/imag sample, signed two's complement.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: global advance. When low, all state and outputs hold.
- `in_valid` in 1: input sample present this cycle.
- `in_re` in DATA_W: real part of the input sample, signed.
- `in_im` in DATA_W: imaginary part of the input sample, signed.
- `out_valid` in/out: out 1: output sample valid.
- `out_re` out DATA_W: real part of the output sample, natural order.
- `out_im` out DATA_W: imaginary part of the output sample, natural order.
- `out_first` out 1: high with output index 0.
- `out_last` out 1: high with output index N-1.

## Operation
- Storage is two banks of N entries (re and im). Each bank has a full flag. `wr_bank` and `rd_bank` are 1-bit bank pointers.
- Write side:
  - On an edge with `enable` and `in_valid` both high, store the sample at `bank[wr_bank][bitrev(wr_cnt)]`, then increment `wr_cnt`, which is N_LOG2 bits wide.
  - The k-th accepted input is frame index bitrev(k). `bitrev` mirrors all N_LOG2 bits.
  - When `wr_cnt` wraps from N-1 to 0, set `full[wr_bank]` and toggle `wr_bank`.
- Read side, two-state FSM:
  - IDLE: if `full[rd_bank]` is set, go to READ and set `rd_cnt` to 0.
  - READ: each enabled edge loads `out_re`/`out_im` from `bank[rd_bank][rd_cnt]` and asserts `out_valid`. `out_first` is driven as (`rd_cnt` == 0) and `out_last` as (`rd_cnt` == N-1). Then increment `rd_cnt`.
  - On `rd_cnt` == N-1: clear `full[rd_bank]` and toggle `rd_bank`.
  - After that toggle, if the other bank is already full (or becomes full on this same edge), stay in READ with `rd_cnt` = 0. The output stream is then gapless. Otherwise go to IDLE.
- In IDLE, or on any enabled edge that loads nothing, `out_valid`, `out_first` and `out_last` drop to 0. `out_re`/`out_im` keep their last value.
- No backpressure. With at most one input per cycle, the writer cannot refill a bank before the reader drains it, so overrun is impossible by construction.
- A write into `wr_bank` never targets `rd_bank` while that bank is being read.
- Input gaps (`in_valid` low) just pause the write counter. Partial frames stay pending indefinitely.

## Timing
- Reset (async assert): `out_valid`, `out_first`, `out_last`, `out_re`, `out_im` go to 0. Counters, bank pointers and full flags go to 0. FSM goes to IDLE.
- Memory contents are not reset.
- Reset mid-frame discards both the partial write frame and any pending or in-progress read frame.
- Latency: if the last sample of a frame is written at enabled edge E, index 0 appears on the outputs after enabled edge E+1. Index N-1 appears after edge E+N. All counts are in enabled edges.
- Continuous input (one sample per cycle) produces continuous output (`out_valid` stuck high) from the first frame on.
- The boundary where a bank fills on the same edge the reader finishes the other bank must produce no bubble.
- With `enable` low: no write, no read, FSM frozen, all outputs held (including `out_valid` = 1 if it was 1).

## Structure
- Shared `fft_pkg` holds:
  - `DATA_W`;
  - a complex-sample typedef (re/im pair);
  - a `bitrev` function parameterised by width, reused by the twiddle-address logic.
- One sub-module, `fft_reorder_ram`: a single bank with 1 write port (enable, addr, data) and 1 read port, registered read.
- Instantiate `fft_reorder_ram` twice.
- Keep the FSM and counters in the top.

## Test plan
- Reset then one frame, N=16, enable=1, inputs in_re = bitrev(k)·100 for k=0..15: after the edge following the last input, the outputs show `out_re` 0, 100, …, 1500 on consecutive cycles. `out_first` is high with 0, `out_last` is high with 1500, and `out_valid` drops afterwards.
- Three back-to-back frames with continuous `in_valid`: `out_valid` stays high for 48 cycles with no bubble, and `out_first` pulses every 16 cycles.
- Frame with random `in_valid` gaps: output order and values are identical to the gapless case, and output starts 1 enabled edge after the 16th accepted sample.
- Toggle `enable` low for 3 cycles in the middle of the output stream: outputs are held (including `out_valid` = 1), with no lost or repeated index.
- Assert `rst_n` low after 7 inputs of a frame, then release: all outputs are 0. Feeding one full frame then yields exactly 16 correct outputs, with no stale data from the partial frame.
- Parameter sweep N_LOG2 = 2 and 6 with a ramp pattern: natural-order output matches the reference model (scoreboard).

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, complex sample type and the
// index bit-reversal helper used by the reorder buffer and twiddle addressing.
package fft_pkg;

    localparam int DATA_W       = 16;
    // Widest index bitrev() handles; covers the largest supported frame (N = 1024).
    localparam int BITREV_MAX_W = 10;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    // Mirror the low `width` bits of v; the result is right-aligned, upper bits zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                       input int width);
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < width) r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// One bank of the reorder ping-pong buffer: simple dual-port, one write
// port and one registered read port.
module fft_reorder_ram #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Storage write.
    // NOTE: the array has no reset so it maps onto block RAM; <= keeps the
    // write ordered against the read register sampling the same clock edge.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read; the register (not the array) is cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorder buffer behind the SDF FFT: collects each bit-reversed frame into a
// ping-pong pair of banks and streams it back out in natural index order.
module fft_bitrev_reorder #(
    parameter int N_LOG2 = 4,
    parameter int DATA_W = fft_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_first,
    output logic                     out_last
);
    import fft_pkg::*;

    localparam int                WORD_W   = 2 * DATA_W;
    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } rd_state_t;

    rd_state_t         rd_state;
    logic [N_LOG2-1:0] wr_cnt;
    logic [N_LOG2-1:0] rd_cnt;
    logic [N_LOG2-1:0] wr_addr;
    logic              wr_bank;
    logic              rd_bank;
    logic              rd_sel;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_fire;
    logic              wr_wrap;
    logic              rd_fire;
    logic              rd_done;
    logic              other_full;
    logic [1:0]        ram_we;
    logic [1:0]        ram_re;
    logic [WORD_W-1:0] ram_q [2];

    // Handshake decode, bank steering and next full-flag state.
    // NOTE: every signal gets a default at the top so no latch is inferred.
    always_comb begin
        wr_fire    = enable && in_valid;
        wr_wrap    = wr_fire && (wr_cnt == CNT_LAST);
        // The bank under the read pointer is drained whenever it is full.
        rd_fire    = enable && full[rd_bank];
        rd_done    = rd_fire && (rd_cnt == CNT_LAST);
        // Next bank ready, counting a fill landing on this very edge.
        other_full = full[~rd_bank] || (wr_wrap && (wr_bank != rd_bank));
        wr_addr    = N_LOG2'(bitrev(BITREV_MAX_W'(wr_cnt), N_LOG2));
        ram_we     = {wr_fire && wr_bank, wr_fire && !wr_bank};
        ram_re     = {rd_fire && rd_bank, rd_fire && !rd_bank};
        full_nxt   = full;
        if (wr_wrap) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    // Write side: frame counter, write bank pointer and bank full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_wrap) wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM: IDLE fetches index 0 on the same edge it sees a full bank,
    // so output begins one enabled edge after the frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state  <= ST_IDLE;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_sel    <= 1'b0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (enable) begin
            out_valid <= rd_fire;
            out_first <= rd_fire && (rd_cnt == '0);
            out_last  <= rd_done;
            if (rd_fire) begin
                rd_sel <= rd_bank;
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (rd_done) rd_bank <= ~rd_bank;
            case (rd_state)
                ST_IDLE: if (rd_fire) rd_state <= ST_READ;
                ST_READ: if (rd_done) rd_state <= other_full ? ST_READ : ST_IDLE;
                default: rd_state <= ST_IDLE;
            endcase
        end
    end

    // Output data comes straight from the bank read register last loaded.
    always_comb begin
        out_re = rd_sel ? ram_q[1][WORD_W-1:DATA_W] : ram_q[0][WORD_W-1:DATA_W];
        out_im = rd_sel ? ram_q[1][DATA_W-1:0]      : ram_q[0][DATA_W-1:0];
    end

    fft_reorder_ram #(.ADDR_W(N_LOG2), .WORD_W(WORD_W)) u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we[0]),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (ram_re[0]),
        .rd_addr (rd_cnt),
        .rd_data (ram_q[0])
    );

    fft_reorder_ram #(.ADDR_W(N_LOG2), .WORD_W(WORD_W)) u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we[1]),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_im}),
        .rd_en   (ram_re[1]),
        .rd_addr (rd_cnt),
        .rd_data (ram_q[1])
    );

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: drivers push expected natural-order
// samples per frame, monitors pop and compare on every new output sample.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    typedef struct packed {
        cplx_t d;
        logic  first;
        logic  last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;

    // N = 16 instance
    logic               m_valid = 1'b0;
    logic signed [15:0] m_re = '0, m_im = '0;
    logic               mo_valid, mo_first, mo_last;
    logic signed [15:0] mo_re, mo_im;
    // N = 4 instance
    logic               a_valid = 1'b0;
    logic signed [15:0] a_re = '0, a_im = '0;
    logic               ao_valid, ao_first, ao_last;
    logic signed [15:0] ao_re, ao_im;
    // N = 64 instance
    logic               b_valid = 1'b0;
    logic signed [15:0] b_re = '0, b_im = '0;
    logic               bo_valid, bo_first, bo_last;
    logic signed [15:0] bo_re, bo_im;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q_m[$];
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.N_LOG2(4), .DATA_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(m_valid),
        .in_re(m_re), .in_im(m_im), .out_valid(mo_valid), .out_re(mo_re),
        .out_im(mo_im), .out_first(mo_first), .out_last(mo_last));

    fft_bitrev_reorder #(.N_LOG2(2), .DATA_W(16)) u_n2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(a_valid),
        .in_re(a_re), .in_im(a_im), .out_valid(ao_valid), .out_re(ao_re),
        .out_im(ao_im), .out_first(ao_first), .out_last(ao_last));

    fft_bitrev_reorder #(.N_LOG2(6), .DATA_W(16)) u_n6 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(b_valid),
        .in_re(b_re), .in_im(b_im), .out_valid(bo_valid), .out_re(bo_re),
        .out_im(bo_im), .out_first(bo_first), .out_last(bo_last));

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic extra(input string name, input logic signed [15:0] re);
        n_checks++;
        $display("FAIL %s: output re=%0d with no expected sample (t=%0t)", name, re, $time);
    endtask

    function automatic int rev(input int v, input int w);
        int r = 0;
        for (int i = 0; i < w; i++) if (v[i]) r |= (1 << (w - 1 - i));
        return r;
    endfunction

    // ---------------- monitors ----------------
    always @(posedge clk) begin : mon_m
        logic en_s;
        exp_t e;
        en_s = enable;
        #1;
        if (en_s && mo_valid) begin
            if (q_m.size() == 0) extra("m_extra", mo_re);
            else begin
                e = q_m.pop_front();
                check("m_re", mo_re, e.d.re);
                check("m_im", mo_im, e.d.im);
                check("m_first_last", {mo_first, mo_last}, {e.first, e.last});
            end
        end
    end

    always @(posedge clk) begin : mon_a
        logic en_s;
        exp_t e;
        en_s = enable;
        #1;
        if (en_s && ao_valid) begin
            if (q_a.size() == 0) extra("n2_extra", ao_re);
            else begin
                e = q_a.pop_front();
                check("n2_re", ao_re, e.d.re);
                check("n2_im", ao_im, e.d.im);
                check("n2_first_last", {ao_first, ao_last}, {e.first, e.last});
            end
        end
    end

    always @(posedge clk) begin : mon_b
        logic en_s;
        exp_t e;
        en_s = enable;
        #1;
        if (en_s && bo_valid) begin
            if (q_b.size() == 0) extra("n6_extra", bo_re);
            else begin
                e = q_b.pop_front();
                check("n6_re", bo_re, e.d.re);
                check("n6_im", bo_im, e.d.im);
                check("n6_first_last", {bo_first, bo_last}, {e.first, e.last});
            end
        end
    end

    // ---------------- N=16 driver ----------------
    // Input k of a frame carries re = base_re + rev(k)*100, im = base_im - rev(k),
    // so natural output index i reads re = base_re + i*100, im = base_im - i.
    task automatic send_frame(input int base_re, input int base_im, input int gap_pct);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(negedge clk);
                m_valid = 1'b0;
            end
            @(negedge clk);
            m_valid = 1'b1;
            m_re    = 16'(base_re + rev(k, 4) * 100);
            m_im    = 16'(base_im - rev(k, 4));
        end
        for (int i = 0; i < 16; i++) begin
            e.d.re  = 16'(base_re + i * 100);
            e.d.im  = 16'(base_im - i);
            e.first = (i == 0);
            e.last  = (i == 15);
            q_m.push_back(e);
        end
    endtask

    // Called right after the last sample is set up: edge E stores it, edge E+1 shows index 0.
    task automatic check_latency(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_at_E"}, mo_valid, 0);
        @(negedge clk);
        m_valid = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_valid_at_E1"}, mo_valid, 1);
        check({tag, "_first_at_E1"}, mo_first, 1);
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while ((q_m.size() != 0 || q_a.size() != 0 || q_b.size() != 0 ||
                mo_valid || ao_valid || bo_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_checks++;
            $display("FAIL %s_drain: timeout, pending m=%0d n2=%0d n6=%0d", tag,
                     q_m.size(), q_a.size(), q_b.size());
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int run;
        int firsts;
        int t;

        // Reset state
        #12;
        check("rst_valid", mo_valid, 0);
        check("rst_re", mo_re, 0);
        check("rst_im", mo_im, 0);
        check("rst_first_last", {mo_first, mo_last}, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // 1: single frame, re = bitrev(k)*100 -> 0..1500 in order
        send_frame(0, 0, 0);
        check_latency("t1");
        wait_drain("t1");
        check("t1_valid_dropped", mo_valid, 0);

        // 2: three back-to-back frames, gapless 48-sample output run
        fork
            begin
                send_frame(0, 0, 0);
                send_frame(2000, -50, 0);
                send_frame(4000, -100, 0);
                @(negedge clk);
                m_valid = 1'b0;
            end
            begin
                t = 0;
                while (!mo_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                run = 0;
                firsts = 0;
                while (mo_valid && run < 100) begin
                    if (mo_first) begin
                        firsts++;
                        check("t2_first_pos", run % 16, 0);
                    end
                    run++;
                    @(negedge clk);
                end
                check("t2_gapless_run", run, 48);
                check("t2_first_count", firsts, 3);
            end
        join
        wait_drain("t2");

        // 3: random input gaps, same values as frame 1
        send_frame(0, 0, 40);
        check_latency("t3");
        wait_drain("t3");

        // 4: enable low for 3 cycles mid-stream; index 4 (re 700) must hold
        send_frame(300, 20, 0);
        @(negedge clk);
        m_valid = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", mo_valid, 1);
            check("t4_hold_re", mo_re, 700);
            check("t4_hold_im", mo_im, 16);
        end
        enable = 1'b1;
        wait_drain("t4");

        // 5: reset after 7 inputs discards the partial frame
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            m_valid = 1'b1;
            m_re    = 16'(9000 + k);
            m_im    = 16'(-9000 - k);
        end
        @(negedge clk);
        m_valid = 1'b0;
        rst_n   = 1'b0;
        #2;
        check("t5_rst_valid", mo_valid, 0);
        check("t5_rst_re", mo_re, 0);
        check("t5_rst_im", mo_im, 0);
        check("t5_rst_first_last", {mo_first, mo_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(50, -3, 0);
        @(negedge clk);
        m_valid = 1'b0;
        wait_drain("t5");
        repeat (20) @(negedge clk);

        // 6: N=4 (two frames) and N=64 ramp through the reference bitrev model
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                a_valid = 1'b1;
                a_re    = 16'(f * 16 + k);
                a_im    = 16'(-(f * 16 + k));
            end
            for (int i = 0; i < 4; i++)
                q_a.push_back('{d: '{re: 16'(f * 16 + rev(i, 2)), im: 16'(-(f * 16 + rev(i, 2)))},
                                first: (i == 0), last: (i == 3)});
        end
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            b_valid = 1'b1;
            b_re    = 16'(k);
            b_im    = 16'(1000 - k);
        end
        for (int i = 0; i < 64; i++)
            q_b.push_back('{d: '{re: 16'(rev(i, 6)), im: 16'(1000 - rev(i, 6))},
                            first: (i == 0), last: (i == 63)});
        @(negedge clk);
        b_valid = 1'b0;
        wait_drain("t6");
        repeat (10) @(negedge clk);

        check("m_queue_left", q_m.size(), 0);
        check("n2_queue_left", q_a.size(), 0);
        check("n6_queue_left", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
